// File: rtl/ex_mem_wb_pipeline.sv
// Execute, memory and writeback stages of the five-stage pipeline: ID/EX, EX/MEM and
// MEM/WB registers, the ALU, data-memory access and the writeback mux.
module ex_mem_wb_pipeline (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] id_shiftAmount,
    input  logic [31:0] id_immediate,
    input  logic [31:0] id_registerRsOrPc_4,
    input  logic [31:0] id_registerRtOrZero,
    input  logic [3:0]  id_aluOperation,
    input  logic        id_shouldAluUseShiftAmountElseRegisterRsOrPc_4,
    input  logic        id_shouldAluUseImmeidateElseRegisterRtOrZero,
    input  logic        id_shouldWriteRegister,
    input  logic [4:0]  id_registerWriteAddress,
    input  logic        id_shouldWriteMemoryElseAluOutputToRegister,
    input  logic        id_shouldWriteMemory,
    input  logic        id_shouldStall,
    output logic [31:0] dataMemoryAddress,
    output logic [31:0] dataMemoryWriteData,
    output logic        dataMemoryWriteEnable,
    input  logic [31:0] dataMemoryReadData,
    output logic        ex_shouldWriteRegister,
    output logic        ex_shouldWriteMemoryElseAluOutputToRegister,
    output logic [4:0]  ex_registerWriteAddress,
    output logic [31:0] ex_aluOutput,
    output logic        mem_shouldWriteRegister,
    output logic        mem_shouldWriteMemoryElseAluOutputToRegister,
    output logic [4:0]  mem_registerWriteAddress,
    output logic [31:0] mem_aluOutput,
    output logic        wb_shouldWriteRegister,
    output logic [4:0]  wb_registerWriteAddress,
    output logic [31:0] wb_registerWriteData
);

    // ID/EX register
    logic [31:0] ex_shamt_q, ex_shamt_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [31:0] ex_rs_q, ex_rs_d;
    logic [31:0] ex_rt_q, ex_rt_d;
    logic [3:0]  ex_aluc_q, ex_aluc_d;
    logic        ex_shift_q, ex_shift_d;
    logic        ex_aluimm_q, ex_aluimm_d;
    logic        ex_wreg_q, ex_wreg_d;
    logic [4:0]  ex_waddr_q, ex_waddr_d;
    logic        ex_m2reg_q, ex_m2reg_d;
    logic        ex_wmem_q, ex_wmem_d;

    // EX/MEM register
    logic [31:0] mem_alu_q, mem_alu_d;
    logic [31:0] mem_st_q, mem_st_d;
    logic        mem_wreg_q, mem_wreg_d;
    logic [4:0]  mem_waddr_q, mem_waddr_d;
    logic        mem_m2reg_q, mem_m2reg_d;
    logic        mem_wmem_q, mem_wmem_d;

    // MEM/WB register
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic        wb_wreg_q, wb_wreg_d;
    logic [4:0]  wb_waddr_q, wb_waddr_d;
    logic        wb_m2reg_q, wb_m2reg_d;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;

    always_comb begin
        op_a = ex_shift_q  ? ex_shamt_q : ex_rs_q;
        op_b = ex_aluimm_q ? ex_imm_q   : ex_rt_q;
        alu_result = '0;
        case (ex_aluc_q[2:0])
            3'b000:  alu_result = op_a + op_b;
            3'b100:  alu_result = op_a - op_b;
            3'b001:  alu_result = op_a & op_b;
            3'b101:  alu_result = op_a | op_b;
            3'b010:  alu_result = op_a ^ op_b;
            3'b110:  alu_result = {op_b[15:0], 16'h0000};
            3'b011:  alu_result = op_b << op_a[4:0];
            3'b111: begin
                if (ex_aluc_q[3]) alu_result = 32'($signed(op_b) >>> op_a[4:0]);
                else              alu_result = op_b >> op_a[4:0];
            end
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        ex_shamt_d  = id_shiftAmount;
        ex_imm_d    = id_immediate;
        ex_rs_d     = id_registerRsOrPc_4;
        ex_rt_d     = id_registerRtOrZero;
        ex_aluc_d   = id_aluOperation;
        ex_shift_d  = id_shouldAluUseShiftAmountElseRegisterRsOrPc_4;
        ex_aluimm_d = id_shouldAluUseImmeidateElseRegisterRtOrZero;
        ex_waddr_d  = id_registerWriteAddress;
        // A write to $0 is dropped here so it can never be written back or forwarded.
        ex_wreg_d   = id_shouldWriteRegister && (id_registerWriteAddress != 5'd0) && !id_shouldStall;
        ex_m2reg_d  = id_shouldWriteMemoryElseAluOutputToRegister && !id_shouldStall;
        ex_wmem_d   = id_shouldWriteMemory && !id_shouldStall;

        mem_alu_d   = alu_result;
        mem_st_d    = ex_rt_q;
        mem_wreg_d  = ex_wreg_q;
        mem_waddr_d = ex_waddr_q;
        mem_m2reg_d = ex_m2reg_q;
        mem_wmem_d  = ex_wmem_q;

        wb_alu_d    = mem_alu_q;
        wb_rdata_d  = dataMemoryReadData;
        wb_wreg_d   = mem_wreg_q;
        wb_waddr_d  = mem_waddr_q;
        wb_m2reg_d  = mem_m2reg_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_shamt_q  <= '0;
            ex_imm_q    <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_aluc_q   <= '0;
            ex_shift_q  <= 1'b0;
            ex_aluimm_q <= 1'b0;
            ex_wreg_q   <= 1'b0;
            ex_waddr_q  <= '0;
            ex_m2reg_q  <= 1'b0;
            ex_wmem_q   <= 1'b0;
            mem_alu_q   <= '0;
            mem_st_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_waddr_q <= '0;
            mem_m2reg_q <= 1'b0;
            mem_wmem_q  <= 1'b0;
            wb_alu_q    <= '0;
            wb_rdata_q  <= '0;
            wb_wreg_q   <= 1'b0;
            wb_waddr_q  <= '0;
            wb_m2reg_q  <= 1'b0;
        end else begin
            ex_shamt_q  <= ex_shamt_d;
            ex_imm_q    <= ex_imm_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            ex_aluc_q   <= ex_aluc_d;
            ex_shift_q  <= ex_shift_d;
            ex_aluimm_q <= ex_aluimm_d;
            ex_wreg_q   <= ex_wreg_d;
            ex_waddr_q  <= ex_waddr_d;
            ex_m2reg_q  <= ex_m2reg_d;
            ex_wmem_q   <= ex_wmem_d;
            mem_alu_q   <= mem_alu_d;
            mem_st_q    <= mem_st_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_waddr_q <= mem_waddr_d;
            mem_m2reg_q <= mem_m2reg_d;
            mem_wmem_q  <= mem_wmem_d;
            wb_alu_q    <= wb_alu_d;
            wb_rdata_q  <= wb_rdata_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_m2reg_q  <= wb_m2reg_d;
        end
    end

    assign ex_shouldWriteRegister                       = ex_wreg_q;
    assign ex_shouldWriteMemoryElseAluOutputToRegister  = ex_m2reg_q;
    assign ex_registerWriteAddress                      = ex_waddr_q;
    assign ex_aluOutput                                 = alu_result;

    assign mem_shouldWriteRegister                      = mem_wreg_q;
    assign mem_shouldWriteMemoryElseAluOutputToRegister = mem_m2reg_q;
    assign mem_registerWriteAddress                     = mem_waddr_q;
    assign mem_aluOutput                                = mem_alu_q;
    assign dataMemoryAddress                            = mem_alu_q;
    assign dataMemoryWriteData                          = mem_st_q;
    assign dataMemoryWriteEnable                        = mem_wmem_q;

    assign wb_shouldWriteRegister                       = wb_wreg_q;
    assign wb_registerWriteAddress                      = wb_waddr_q;
    assign wb_registerWriteData                         = wb_m2reg_q ? wb_rdata_q : wb_alu_q;

endmodule

// File: tb/tb_ex_mem_wb_pipeline.sv
// Bench for ex_mem_wb_pipeline: directed and random instructions against a program-order
// reference model, with a small word memory attached to the data port.
module tb_ex_mem_wb_pipeline;

    logic        clock;
    logic        reset;
    logic [31:0] id_shiftAmount, id_immediate, id_registerRsOrPc_4, id_registerRtOrZero;
    logic [3:0]  id_aluOperation;
    logic        id_shift, id_aluimm, id_wreg, id_m2reg, id_wmem, id_stall;
    logic [4:0]  id_waddr;
    logic [31:0] dataMemoryAddress, dataMemoryWriteData, dataMemoryReadData;
    logic        dataMemoryWriteEnable;
    logic        ex_wreg, ex_m2reg, mem_wreg, mem_m2reg, wb_wreg;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_alu, mem_alu, wb_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] shamt, imm, rs, rt;
        logic [3:0]  aluc;
        logic        shift, aluimm, wreg, m2reg, wmem, stall;
        logic [4:0]  waddr;
    } in_t;

    typedef struct {
        logic        bubble, wreg, m2reg, wmem;
        logic [4:0]  waddr;
        logic [31:0] alu, st, wbd;
    } exp_t;

    in_t  prog[$];
    exp_t expv[$];

    logic [31:0] mem [64];
    logic [31:0] init_mem [64];
    logic [31:0] ref_mem [64];
    logic        mem_load;

    ex_mem_wb_pipeline dut (
        .clock(clock),
        .reset(reset),
        .id_shiftAmount(id_shiftAmount),
        .id_immediate(id_immediate),
        .id_registerRsOrPc_4(id_registerRsOrPc_4),
        .id_registerRtOrZero(id_registerRtOrZero),
        .id_aluOperation(id_aluOperation),
        .id_shouldAluUseShiftAmountElseRegisterRsOrPc_4(id_shift),
        .id_shouldAluUseImmeidateElseRegisterRtOrZero(id_aluimm),
        .id_shouldWriteRegister(id_wreg),
        .id_registerWriteAddress(id_waddr),
        .id_shouldWriteMemoryElseAluOutputToRegister(id_m2reg),
        .id_shouldWriteMemory(id_wmem),
        .id_shouldStall(id_stall),
        .dataMemoryAddress(dataMemoryAddress),
        .dataMemoryWriteData(dataMemoryWriteData),
        .dataMemoryWriteEnable(dataMemoryWriteEnable),
        .dataMemoryReadData(dataMemoryReadData),
        .ex_shouldWriteRegister(ex_wreg),
        .ex_shouldWriteMemoryElseAluOutputToRegister(ex_m2reg),
        .ex_registerWriteAddress(ex_waddr),
        .ex_aluOutput(ex_alu),
        .mem_shouldWriteRegister(mem_wreg),
        .mem_shouldWriteMemoryElseAluOutputToRegister(mem_m2reg),
        .mem_registerWriteAddress(mem_waddr),
        .mem_aluOutput(mem_alu),
        .wb_shouldWriteRegister(wb_wreg),
        .wb_registerWriteAddress(wb_waddr),
        .wb_registerWriteData(wb_wdata)
    );

    // Clock and data memory: combinational read, write on the rising edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign dataMemoryReadData = mem[dataMemoryAddress[7:2]];

    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (dataMemoryWriteEnable) begin
            mem[dataMemoryAddress[7:2]] <= dataMemoryWriteData;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // ALUC codes per operation kind; the first six ignore bit 3.
    function automatic logic [3:0] aluc_of(input int kind);
        logic [3:0] t;
        logic       x;
        x = 1'($urandom_range(0, 1));
        case (kind)
            0: t = {x, 3'b000};
            1: t = {x, 3'b100};
            2: t = {x, 3'b001};
            3: t = {x, 3'b101};
            4: t = {x, 3'b010};
            5: t = {x, 3'b110};
            6: t = 4'b0011;
            7: t = 4'b0111;
            default: t = 4'b1111;
        endcase
        return t;
    endfunction

    function automatic in_t mk(input int kind, input logic [31:0] shamt, imm, rs, rt,
                               input logic shift, aluimm, wreg, input logic [4:0] waddr,
                               input logic m2reg, wmem, stall);
        in_t r;
        r.kind = kind; r.shamt = shamt; r.imm = imm; r.rs = rs; r.rt = rt;
        r.aluc = aluc_of(kind); r.shift = shift; r.aluimm = aluimm; r.wreg = wreg;
        r.waddr = waddr; r.m2reg = m2reg; r.wmem = wmem; r.stall = stall;
        return r;
    endfunction

    // Reference model, applied in program order: loads see every earlier store.
    task automatic model_step(input in_t x, output exp_t e);
        logic [31:0] a, b, r;
        a = x.shift ? x.shamt : x.rs;
        b = x.aluimm ? x.imm : x.rt;
        case (x.kind)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = b * 32'h0001_0000;
            6: r = b << (a % 32);
            7: r = b >> (a % 32);
            default: r = 32'($signed(b) >>> (a % 32));
        endcase
        e.bubble = x.stall;
        e.wreg   = x.wreg && !x.stall && (x.waddr != 0);
        e.m2reg  = x.m2reg && !x.stall;
        e.wmem   = x.wmem && !x.stall;
        e.waddr  = x.waddr;
        e.alu    = r;
        e.st     = x.rt;
        e.wbd    = e.m2reg ? ref_mem[r[7:2]] : r;
        if (e.wmem) ref_mem[r[7:2]] = x.rt;
    endtask

    task automatic add_instr(input in_t x);
        exp_t e;
        model_step(x, e);
        prog.push_back(x);
        expv.push_back(e);
    endtask

    function automatic in_t rand_instr();
        return mk(int'($urandom_range(0, 8)), $urandom, $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
    endfunction

    task automatic drive(input in_t x);
        id_shiftAmount      = x.shamt;
        id_immediate        = x.imm;
        id_registerRsOrPc_4 = x.rs;
        id_registerRtOrZero = x.rt;
        id_aluOperation     = x.aluc;
        id_shift            = x.shift;
        id_aluimm           = x.aluimm;
        id_wreg             = x.wreg;
        id_waddr            = x.waddr;
        id_m2reg            = x.m2reg;
        id_wmem             = x.wmem;
        id_stall            = x.stall;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ex_wreg"}, 32'(ex_wreg), 0);
        check({tag, "_ex_m2reg"}, 32'(ex_m2reg), 0);
        check({tag, "_ex_waddr"}, 32'(ex_waddr), 0);
        check({tag, "_ex_alu"}, ex_alu, 0);
        check({tag, "_mem_wreg"}, 32'(mem_wreg), 0);
        check({tag, "_mem_m2reg"}, 32'(mem_m2reg), 0);
        check({tag, "_mem_waddr"}, 32'(mem_waddr), 0);
        check({tag, "_mem_alu"}, mem_alu, 0);
        check({tag, "_dm_addr"}, dataMemoryAddress, 0);
        check({tag, "_dm_wdata"}, dataMemoryWriteData, 0);
        check({tag, "_dm_we"}, 32'(dataMemoryWriteEnable), 0);
        check({tag, "_wb_wreg"}, 32'(wb_wreg), 0);
        check({tag, "_wb_waddr"}, 32'(wb_waddr), 0);
        check({tag, "_wb_wdata"}, wb_wdata, 0);
    endtask

    task automatic check_stages(input int c);
        int n;
        n = prog.size();
        if (c - 1 >= 0 && c - 1 < n) begin
            exp_t e;
            e = expv[c - 1];
            check("ex_wreg", 32'(ex_wreg), 32'(e.wreg));
            check("ex_m2reg", 32'(ex_m2reg), 32'(e.m2reg));
            if (!e.bubble) check("ex_alu", ex_alu, e.alu);
            if (e.wreg) check("ex_waddr", 32'(ex_waddr), 32'(e.waddr));
        end
        if (c - 2 >= 0 && c - 2 < n) begin
            exp_t e;
            e = expv[c - 2];
            check("mem_wreg", 32'(mem_wreg), 32'(e.wreg));
            check("mem_m2reg", 32'(mem_m2reg), 32'(e.m2reg));
            check("dm_we", 32'(dataMemoryWriteEnable), 32'(e.wmem));
            if (!e.bubble) begin
                check("mem_alu", mem_alu, e.alu);
                check("dm_addr", dataMemoryAddress, e.alu);
            end
            if (e.wmem) check("dm_wdata", dataMemoryWriteData, e.st);
            if (e.wreg) check("mem_waddr", 32'(mem_waddr), 32'(e.waddr));
        end
        if (c - 3 >= 0 && c - 3 < n) begin
            exp_t e;
            e = expv[c - 3];
            check("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
            if (e.wreg) check("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
            if (!e.bubble) check("wb_wdata", wb_wdata, e.wbd);
        end
    endtask

    initial begin
        in_t nop, x;
        logic [31:0] saved;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop.aluc = 4'b0000;

        for (int i = 0; i < 64; i++) begin
            init_mem[i] = $urandom;
            ref_mem[i]  = init_mem[i];
        end

        // Reset with a live store and stall on the inputs: reset must win.
        reset = 1'b1;
        mem_load = 1'b1;
        x = mk(0, 1, 2, 3, 4, 0, 0, 1, 5'd9, 1, 1, 1);
        drive(x);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("rst");

        // Directed program, then random traffic, then drain.
        add_instr(mk(0, 0, 0, 5, 7, 0, 0, 1, 5'd3, 0, 0, 0));
        add_instr(mk(8, 4, 0, 0, 32'h8000_0000, 1, 0, 1, 5'd4, 0, 0, 0));
        add_instr(mk(5, 0, 32'h1234, 0, 0, 0, 1, 1, 5'd5, 0, 0, 0));
        add_instr(mk(0, 0, 4, 32'h10, 32'hDEAD_BEEF, 0, 1, 0, 5'd0, 0, 1, 0));
        add_instr(mk(0, 0, 4, 32'h10, 0, 0, 1, 1, 5'd6, 1, 0, 0));
        add_instr(mk(0, 0, 0, 11, 22, 0, 0, 1, 5'd8, 0, 0, 1));
        add_instr(mk(1, 0, 0, 50, 8, 0, 0, 1, 5'd8, 0, 0, 0));
        add_instr(mk(3, 0, 0, 32'hF0, 32'h0F, 0, 0, 1, 5'd0, 0, 0, 0));
        add_instr(mk(0, 0, 0, 1, 1, 0, 0, 1, 5'd7, 0, 1, 1));
        add_instr(mk(0, 0, 0, 1, 1, 0, 0, 1, 5'd7, 1, 0, 1));
        add_instr(mk(6, 31, 0, 0, 32'h3, 1, 0, 1, 5'd10, 0, 0, 0));
        add_instr(mk(7, 0, 0, 36, 32'h8000_0001, 0, 0, 1, 5'd11, 0, 0, 0));
        for (int i = 0; i < 200; i++) add_instr(rand_instr());
        for (int i = 0; i < 4; i++) add_instr(nop);

        for (int c = 0; c < prog.size() + 3; c++) begin
            @(posedge clock);
            #1;
            reset = 1'b0;
            mem_load = 1'b0;
            drive(c < prog.size() ? prog[c] : nop);
            @(negedge clock);
            check_stages(c);
        end

        // Reset while a store sits in EX: the store must never reach memory.
        x = mk(0, 0, 8, 32'h20, 32'h1234_5678, 0, 1, 0, 5'd0, 0, 1, 0);
        saved = mem[6'h0A];
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            case (c)
                0: drive(mk(0, 0, 0, 3, 4, 0, 0, 1, 5'd12, 0, 0, 0));
                1: drive(mk(2, 0, 0, 32'hFF, 32'h0F, 0, 0, 1, 5'd13, 0, 0, 0));
                2: drive(x);
                default: drive(nop);
            endcase
            reset = (c == 3);
            @(negedge clock);
            check("midrst_we", 32'(dataMemoryWriteEnable), 0);
            if (c == 4) check_all_zero("midrst");
        end
        check("midrst_mem", mem[6'h0A], saved);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
